// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_pkg : shared constants for the WISC MEM/WB writeback stage
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_stage_pkg;

  localparam int DW        = 16;
  localparam int NREG      = 16;
  localparam int REG_IDX_W = $clog2(NREG);
  localparam int RET_W     = 16;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PCS = 2'b10;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  // Writeback source select; the reserved encoding falls back to the ALU.
  function automatic logic [DW-1:0] wb_mux(
    input logic [1:0]    sel,
    input logic [DW-1:0] alu,
    input logic [DW-1:0] mem,
    input logic [DW-1:0] pcs
  );
    logic [DW-1:0] res;
    res = alu;
    case (sel)
      WB_SEL_MEM: res = mem;
      WB_SEL_PCS: res = pcs;
      default:    res = alu;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_stage_write_decoder.sv
// ---------------------------------------------------------------------------
// write_decoder : register index + enable -> one-hot register write strobe
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module write_decoder #(
  parameter int NREG = 16,
  parameter int IW   = $clog2(NREG)
) (
  input  logic [IW-1:0]   idx_i,
  input  logic            en_i,
  output logic [NREG-1:0] onehot_o
);

  for (genvar i = 0; i < NREG; i++) begin : g_bit
    assign onehot_o[i] = en_i && (idx_i == IW'(i));
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage : MEM/WB pipeline register, writeback select, halt flag, retire count
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_stage #(
  parameter int DW   = 16,
  parameter int NREG = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    mem_valid,
  input  logic                    mem_reg_write,
  input  logic [$clog2(NREG)-1:0] mem_dst_reg,
  input  logic [1:0]              mem_wb_sel,
  input  logic [DW-1:0]           mem_alu_result,
  input  logic [DW-1:0]           mem_rd_data,
  input  logic [DW-1:0]           mem_pc_plus2,
  input  logic                    mem_halt,
  output logic [DW-1:0]           wb_data,
  output logic [NREG-1:0]         wb_write_en,
  output logic                    wb_reg_write,
  output logic [$clog2(NREG)-1:0] wb_dst_reg,
  output logic                    wb_valid,
  output logic                    halted,
  output logic [15:0]             retired
);

  import wb_stage_pkg::*;

  localparam int IW = $clog2(NREG);

  logic          valid_q,     valid_d;
  logic          reg_write_q, reg_write_d;
  logic [IW-1:0] dst_q,       dst_d;
  logic [DW-1:0] data_q,      data_d;
  logic          halt_q,      halt_d;
  logic          halted_q,    halted_d;
  logic [15:0]   retired_q,   retired_d;

  logic          w_halt_now;
  logic [DW-1:0] w_sel_data;

  assign w_sel_data = wb_mux(mem_wb_sel, mem_alu_result, mem_rd_data, mem_pc_plus2);

  // An HLT sitting in WB already blocks the capture on the edge that sets halted.
  assign w_halt_now = halted_q | (valid_q & halt_q);

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    dst_d       = dst_q;
    data_d      = data_q;
    halt_d      = halt_q;
    halted_d    = w_halt_now;
    retired_d   = retired_q;

    if (w_halt_now || flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      dst_d       = '0;
      data_d      = '0;
      halt_d      = 1'b0;
    end else if (!stall) begin
      valid_d     = mem_valid;
      reg_write_d = mem_valid & mem_reg_write & ~mem_halt & (mem_dst_reg != REG_ZERO);
      dst_d       = mem_dst_reg;
      data_d      = w_sel_data;
      halt_d      = mem_valid & mem_halt;
      if (mem_valid) begin
        retired_d = retired_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      dst_q       <= '0;
      data_q      <= '0;
      halt_q      <= 1'b0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
      halt_q      <= halt_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
    end
  end

  write_decoder #(
    .NREG (NREG),
    .IW   (IW)
  ) u_write_decoder (
    .idx_i    (dst_q),
    .en_i     (reg_write_q),
    .onehot_o (wb_write_en)
  );

  assign wb_data      = data_q;
  assign wb_reg_write = reg_write_q;
  assign wb_dst_reg   = dst_q;
  assign wb_valid     = valid_q;
  assign halted       = halted_q;
  assign retired      = retired_q;

  a_onehot_we : assert property (@(posedge clk) $onehot0(wb_write_en));

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a spec-level reference model.
`default_nettype none

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_valid, mem_reg_write, mem_halt;
  logic [3:0]  mem_dst_reg;
  logic [1:0]  mem_wb_sel;
  logic [15:0] mem_alu_result, mem_rd_data, mem_pc_plus2;
  logic [15:0] wb_data, wb_write_en, retired;
  logic        wb_reg_write, wb_valid, halted;
  logic [3:0]  wb_dst_reg;

  int tests = 0;
  int fails = 0;

  // reference model state (what WB should hold after the most recent edge)
  bit          m_valid, m_rw, m_halt, m_halted;
  int          m_dst;
  logic [15:0] m_data;
  int          m_ret;

  wb_stage #(.DW(16), .NREG(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_dst_reg    (mem_dst_reg),
    .mem_wb_sel     (mem_wb_sel),
    .mem_alu_result (mem_alu_result),
    .mem_rd_data    (mem_rd_data),
    .mem_pc_plus2   (mem_pc_plus2),
    .mem_halt       (mem_halt),
    .wb_data        (wb_data),
    .wb_write_en    (wb_write_en),
    .wb_reg_write   (wb_reg_write),
    .wb_dst_reg     (wb_dst_reg),
    .wb_valid       (wb_valid),
    .halted         (halted),
    .retired        (retired)
  );

  always #5 clk = ~clk;

  task automatic set_mem(input bit v, input bit rw, input int dst, input int sel,
                         input int alu, input int rd, input int pc, input bit h);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_dst_reg    = 4'(dst);
    mem_wb_sel     = 2'(sel);
    mem_alu_result = 16'(alu);
    mem_rd_data    = 16'(rd);
    mem_pc_plus2   = 16'(pc);
    mem_halt       = h;
  endtask

  // Advance the model by the spec rules using the inputs now applied, then clock.
  task automatic tick();
    bit blocked;
    if (rst) begin
      m_valid = 0; m_rw = 0; m_halt = 0; m_halted = 0; m_dst = 0; m_data = 0; m_ret = 0;
    end else begin
      blocked = m_halted || (m_valid && m_halt);
      if (blocked || flush) begin
        m_valid = 0; m_rw = 0; m_halt = 0; m_dst = 0; m_data = 0;
      end else if (!stall) begin
        m_valid = mem_valid;
        m_halt  = mem_valid && mem_halt;
        m_rw    = mem_valid && mem_reg_write && !mem_halt && (mem_dst_reg != 0);
        m_dst   = mem_dst_reg;
        if (mem_wb_sel == 2'b01)      m_data = mem_rd_data;
        else if (mem_wb_sel == 2'b10) m_data = mem_pc_plus2;
        else                          m_data = mem_alu_result;
        if (mem_valid) m_ret = (m_ret + 1) % 65536;
      end
      if (blocked) m_halted = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [54:0] obs;
    set_mem(1, 1, 9, 0, 16'h1111, 0, 0, 0);
    stall = 0; flush = 0; rst = 1;
    tick(); tick();
    obs = {wb_data, wb_write_en, wb_reg_write, wb_dst_reg, wb_valid, halted, retired};
    tests++;
    if (obs !== 55'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 0;
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tests++;
    if (wb_valid !== 1'b0 || retired !== 16'd0) begin
      fails++;
      $display("FAIL idle_after_reset: valid=%b retired=%h expected 0/0000", wb_valid, retired);
    end
  endtask

  task automatic test_alu();
    set_mem(1, 1, 3, 0, 16'h1234, 16'h5555, 16'h0002, 0);
    tick();
    tests++;
    if (wb_write_en !== 16'h0008 || wb_data !== 16'h1234 || retired !== 16'd1 ||
        wb_valid !== 1'b1 || wb_dst_reg !== 4'd3 || wb_reg_write !== 1'b1) begin
      fails++;
      $display("FAIL alu_r3: we=%h data=%h ret=%h v=%b dst=%h rw=%b expected 0008/1234/0001/1/3/1",
               wb_write_en, wb_data, retired, wb_valid, wb_dst_reg, wb_reg_write);
    end
  endtask

  task automatic test_load_pcs();
    set_mem(1, 1, 5, 1, 16'h0002, 16'hBEEF, 16'h0010, 0);
    tick();
    tests++;
    if (wb_data !== 16'hBEEF || wb_write_en !== 16'h0020) begin
      fails++;
      $display("FAIL load_r5: data=%h we=%h expected BEEF/0020", wb_data, wb_write_en);
    end
    set_mem(1, 1, 15, 2, 16'h0003, 16'h7777, 16'h0040, 0);
    tick();
    tests++;
    if (wb_data !== 16'h0040 || wb_write_en !== 16'h8000 || retired !== 16'd3) begin
      fails++;
      $display("FAIL pcs_r15: data=%h we=%h ret=%h expected 0040/8000/0003",
               wb_data, wb_write_en, retired);
    end
    set_mem(1, 1, 6, 3, 16'hA5A5, 16'h7777, 16'h0042, 0);
    tick();
    tests++;
    if (wb_data !== 16'hA5A5 || wb_write_en !== 16'h0040) begin
      fails++;
      $display("FAIL reserved_sel: data=%h we=%h expected A5A5/0040", wb_data, wb_write_en);
    end
  endtask

  task automatic test_r0();
    set_mem(1, 1, 0, 0, 16'hFFFF, 0, 0, 0);
    tick();
    tests++;
    if (wb_write_en !== 16'h0000 || wb_reg_write !== 1'b0 || retired !== 16'd5 ||
        wb_valid !== 1'b1) begin
      fails++;
      $display("FAIL r0_write: we=%h rw=%b ret=%h v=%b expected 0000/0/0005/1",
               wb_write_en, wb_reg_write, retired, wb_valid);
    end
  endtask

  task automatic test_stall_flush();
    set_mem(1, 1, 7, 0, 16'h0777, 0, 0, 0);
    tick();
    set_mem(1, 1, 9, 1, 16'h0999, 16'h9999, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (wb_write_en !== 16'h0080 || wb_data !== 16'h0777 || retired !== 16'd6 ||
          wb_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold[%0d]: we=%h data=%h ret=%h expected 0080/0777/0006",
                 i, wb_write_en, wb_data, retired);
      end
    end
    flush = 1;
    tick();
    tests++;
    if (wb_valid !== 1'b0 || wb_write_en !== 16'h0 || wb_data !== 16'h0 || retired !== 16'd6) begin
      fails++;
      $display("FAIL flush_over_stall: v=%b we=%h data=%h ret=%h expected 0/0000/0000/0006",
               wb_valid, wb_write_en, wb_data, retired);
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_halt();
    set_mem(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tests++;
    if (wb_valid !== 1'b1 || halted !== 1'b0 || retired !== 16'd7 || wb_write_en !== 16'h0) begin
      fails++;
      $display("FAIL hlt_in_wb: v=%b halted=%b ret=%h we=%h expected 1/0/0007/0000",
               wb_valid, halted, retired, wb_write_en);
    end
    set_mem(1, 1, 2, 0, 16'h2222, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (halted !== 1'b1 || wb_write_en !== 16'h0 || wb_valid !== 1'b0 || retired !== 16'd7) begin
        fails++;
        $display("FAIL halted_blocks[%0d]: halted=%b we=%h v=%b ret=%h expected 1/0000/0/0007",
                 i, halted, wb_write_en, wb_valid, retired);
      end
    end
    rst = 1;
    tick();
    rst = 0;
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (halted !== 1'b0 || retired !== 16'd0 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_clears_halt: halted=%b ret=%h v=%b expected 0/0000/0",
               halted, retired, wb_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_we;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 4) == 0);
      mem_valid      = ($urandom_range(0, 3) != 0);
      mem_halt       = ($urandom_range(0, 39) == 0);
      mem_reg_write  = mem_halt ? 1'b0 : 1'($urandom);
      mem_dst_reg    = 4'($urandom);
      mem_wb_sel     = 2'($urandom);
      mem_alu_result = 16'($urandom);
      mem_rd_data    = 16'($urandom);
      mem_pc_plus2   = 16'($urandom);
      tick();
      exp_we = m_rw ? (16'd1 << m_dst) : 16'd0;
      tests++;
      if (wb_valid !== m_valid || wb_reg_write !== m_rw || wb_dst_reg !== 4'(m_dst) ||
          wb_data !== m_data || wb_write_en !== exp_we || halted !== m_halted ||
          retired !== 16'(m_ret)) begin
        fails++;
        $display("FAIL random[%0d]: v=%b rw=%b dst=%h data=%h we=%h hlt=%b ret=%h expected %b/%b/%h/%h/%h/%b/%h",
                 n, wb_valid, wb_reg_write, wb_dst_reg, wb_data, wb_write_en, halted, retired,
                 m_valid, m_rw, 4'(m_dst), m_data, exp_we, m_halted, 16'(m_ret));
      end
    end
    rst = 0; flush = 0; stall = 0;
  endtask

  task automatic test_wrap();
    rst = 1;
    tick();
    rst = 0;
    set_mem(1, 0, 1, 0, 16'h0101, 0, 0, 0);
    for (int i = 0; i < 65535; i++) tick();
    tests++;
    if (retired !== 16'hFFFF) begin
      fails++;
      $display("FAIL retired_preload: got %h expected FFFF", retired);
    end
    tick();
    tests++;
    if (retired !== 16'h0000) begin
      fails++;
      $display("FAIL retired_wrap: got %h expected 0000", retired);
    end
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu();
    test_load_pcs();
    test_r0();
    test_stall_flush();
    test_halt();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline stage of the WISC 16-bit pipelined core. Captures the instruction leaving the memory stage, selects the writeback value (ALU result, load data or PC+2), and drives the register file's write side. It produces the 16-bit data word and one write-enable per register, so every register's `d`/`write_reg` pair is fed directly from this block. It also owns the sticky processor-halt flag and a retired-instruction counter.

## Interface
Parameters:
- `DW`, 16: data width
- `NREG`, 16: number of architectural registers; `log2(NREG)` = 4 bits of register index

Ports:
- `clk`  in  1  core clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hold the WB register contents
- `flush`  in  1  load a bubble into WB
- `mem_valid`  in  1  MEM stage holds a real instruction
- `mem_reg_write`  in  1  instruction writes a register
- `mem_dst_reg`  in  4  destination register index
- `mem_wb_sel`  in  2  writeback source: 00 ALU, 01 load data, 10 PC+2, 11 reserved (treated as ALU)
- `mem_alu_result`  in  16  ALU result
- `mem_rd_data`  in  16  data-memory read data
- `mem_pc_plus2`  in  16  PC+2 of the instruction (PCS)
- `mem_halt`  in  1  instruction is HLT
- `wb_data`  out  16  writeback value, to every register's `d`
- `wb_write_en`  out  16  one-hot register write enable, to each register's `write_reg`
- `wb_reg_write`  out  1  WB writes a register (forwarding unit)
- `wb_dst_reg`  out  4  WB destination index (forwarding unit)
- `wb_valid`  out  1  WB holds a real instruction
- `halted`  out  1  sticky halt flag
- `retired`  out  16  retired-instruction count

## Operation
- WB register fields: valid, reg_write, dst_reg, data (mux result computed at capture), halt.
- Per cycle, priority: `rst` > `halted` > `flush` > `stall` > capture.
  - `rst`: all fields 0, `halted`=0, `retired`=0.
  - `halted`=1: WB loads a bubble every cycle; nothing further retires or writes.
  - `flush`: bubble (valid=0, reg_write=0, halt=0; data/dst_reg 0).
  - `stall`: all fields hold.
  - otherwise: capture MEM inputs; valid=`mem_valid`; reg_write=`mem_valid & mem_reg_write`; halt=`mem_valid & mem_halt`.
- R0 is hardwired zero: a captured write with `mem_dst_reg`=0 forces reg_write=0.
- `wb_write_en` = one-hot of `wb_dst_reg` when `wb_reg_write`, else all zero; never more than one bit set.
- `wb_data` = registered data field; no arithmetic, pure 16-bit select.
- `halted` sets on the edge after a cycle where WB valid & halt are both 1; cleared only by `rst`. HLT never writes a register.
- `retired` increments by 1 on every edge that captures a valid instruction (not on stall-hold edges, not bubbles); HLT counts; wraps 0xFFFF -> 0x0000.

## Timing
- Latency: MEM inputs at edge N appear on all outputs after edge N; register file commits at edge N+1.
- Outputs are purely registered (no combinational path from inputs to outputs).
- Stall with a valid writing instruction re-asserts the same `wb_write_en`/`wb_data` each cycle; rewrite is idempotent.
- `flush` and `stall` both high: flush wins.
- HLT in WB at cycle N: `halted`=1 from cycle N+1; any capture attempted at edge N+1 is discarded.
- Reset values: all outputs 0. Reset asserted mid-stall or mid-halt clears everything on that edge.

## Structure
- Shared package: `WB_SEL_ALU`=2'b00, `WB_SEL_MEM`=2'b01, `WB_SEL_PCS`=2'b10, `REG_ZERO`=4'd0, `DW`, register index width.
- One sub-module: `write_decoder` (4-bit index + enable -> 16-bit one-hot), instantiated once.
- Halt flag and retire counter live in `wb_stage` itself.

## Test plan
- Reset, then ALU write R3 with 0x1234 -> after one edge `wb_write_en`=0x0008, `wb_data`=0x1234, `retired`=1.
- Load to R5 with `mem_rd_data`=0xBEEF, `mem_alu_result`=0x0002; PCS to R15 with `mem_pc_plus2`=0x0040 -> `wb_data`=0xBEEF/0x0040, `wb_write_en`=0x0020/0x8000.
- Write to R0 with data 0xFFFF -> `wb_write_en`=0x0000, `wb_reg_write`=0, `retired` still increments.
- Valid write R7 then `stall` 3 cycles, then `flush`+`stall` together -> outputs held 3 cycles, `retired` +1 only, then bubble (`wb_valid`=0, enables 0).
- HLT followed by valid write R2 -> `halted`=1 one cycle after HLT in WB; R2 enable never asserts; `retired` stops; `rst` clears `halted` and `retired`.
- Preload `retired` to 0xFFFF via 65535 valid captures, one more -> `retired`=0x0000.
